// File: rtl/audio_sample_fetcher_pkg.sv
// Shared definitions for the audio sample fetcher: widths, FIFO sizing,
// fetch FSM encoding and the sample packing helper.
package audio_sample_fetcher_pkg;

  localparam int SAMPLE_W   = 11;
  localparam int ADDR_W     = 24;
  localparam int FIFO_DEPTH = 4;
  localparam int LEVEL_W    = 3;
  localparam int PTR_W      = 2;

  localparam logic [LEVEL_W-1:0] LEVEL_FULL  = LEVEL_W'(FIFO_DEPTH);
  localparam logic [LEVEL_W-1:0] LEVEL_EMPTY = '0;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_REQ_HI  = 3'd1,
    ST_WAIT_HI = 3'd2,
    ST_REQ_LO  = 3'd3,
    ST_WAIT_LO = 3'd4,
    ST_PUSH    = 3'd5
  } fetch_state_t;

  // Only the three low bits of the high byte carry sample data.
  function automatic logic [SAMPLE_W-1:0] pack_sample(input logic [2:0] hi_bits,
                                                      input logic [7:0] lo_byte);
    return {hi_bits, lo_byte};
  endfunction

endpackage

// File: rtl/audio_sample_fetcher_sample_fifo.sv
// Four-entry sample FIFO with synchronous push/pop, flush and occupancy.
// Push when full and pop when empty are ignored; the head entry is always
// visible on pop_data.
module sample_fifo
  import audio_sample_fetcher_pkg::*;
(
  input  logic                clk_in,
  input  logic                reset_n,
  input  logic                flush,
  input  logic                push,
  input  logic [SAMPLE_W-1:0] push_data,
  input  logic                pop,
  output logic [SAMPLE_W-1:0] pop_data,
  output logic [LEVEL_W-1:0]  level
);

  logic [SAMPLE_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr;
  logic [PTR_W-1:0]    rd_ptr;
  logic [LEVEL_W-1:0]  count;
  logic                do_push;
  logic                do_pop;

  assign do_push  = push && (count != LEVEL_FULL);
  assign do_pop   = pop && (count != LEVEL_EMPTY);
  assign pop_data = mem[rd_ptr];
  assign level    = count;

  // Storage write; contents need no reset because count gates every read.
  always_ff @(posedge clk_in) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointer and occupancy tracking; simultaneous push and pop keep the level.
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/audio_sample_fetcher.sv
// Audio sample fetcher: reads two-byte samples from SPI flash into a small
// FIFO and hands one sample to the I2S serializer on each word-clock edge.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting for enable and FIFO room
// REQ_HI   | one-cycle read request for the high byte
// WAIT_HI  | waiting for a fresh rising edge of spi_data_ready
// REQ_LO   | one-cycle read request for the low byte (high address + 1)
// WAIT_LO  | waiting for a fresh rising edge of spi_data_ready
// PUSH     | write the assembled sample, advance the address
module audio_sample_fetcher
  import audio_sample_fetcher_pkg::*;
(
  input  logic                clk_in,
  input  logic                reset_n,
  input  logic                enable,
  input  logic [ADDR_W-1:0]   start_addr,
  input  logic [ADDR_W-1:0]   end_addr,
  input  logic                lrclk,
  output logic                spi_start,
  output logic [ADDR_W-1:0]   spi_addr,
  input  logic                spi_data_ready,
  input  logic [7:0]          spi_data,
  output logic [SAMPLE_W-1:0] sample_data,
  output logic [LEVEL_W-1:0]  fifo_level,
  output logic                underflow
);

  fetch_state_t        state;
  fetch_state_t        state_nxt;

  logic                lr_meta;
  logic                lr_sync;
  logic                lr_prev;
  logic                rdy_prev;
  logic                en_prev;
  logic                abort;

  logic [ADDR_W-1:0]   cur_addr;
  logic [ADDR_W-1:0]   lo_addr;
  logic [ADDR_W-1:0]   next_addr;
  logic [2:0]          hi_bits;
  logic [7:0]          lo_byte;

  logic                lr_event;
  logic                rdy_rise;
  logic                en_rise;
  logic                discard;
  logic                fifo_full;
  logic                fifo_empty;

  logic                fifo_push;
  logic                fifo_pop;
  logic                fifo_flush;
  logic [SAMPLE_W-1:0] fifo_rd_data;

  assign lr_event   = lr_sync & ~lr_prev;
  assign rdy_rise   = spi_data_ready & ~rdy_prev;
  assign en_rise    = enable & ~en_prev;
  // A transaction that saw enable low at any point is finished but not kept.
  assign discard    = ~enable | abort;
  assign fifo_full  = (fifo_level == LEVEL_FULL);
  assign fifo_empty = (fifo_level == LEVEL_EMPTY);

  // Loop playback: wrap once the low byte reaches the inclusive end address.
  assign lo_addr    = cur_addr + ADDR_W'(1);
  assign next_addr  = (lo_addr >= end_addr) ? start_addr : cur_addr + ADDR_W'(2);

  // Fetch FSM state register.
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Fetch FSM next-state logic; WAIT states leave only on a fresh ready edge.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:    if (enable && !fifo_full) state_nxt = ST_REQ_HI;
      ST_REQ_HI:  state_nxt = ST_WAIT_HI;
      ST_WAIT_HI: if (rdy_rise) state_nxt = discard ? ST_IDLE : ST_REQ_LO;
      ST_REQ_LO:  state_nxt = ST_WAIT_LO;
      ST_WAIT_LO: if (rdy_rise) state_nxt = discard ? ST_IDLE : ST_PUSH;
      ST_PUSH:    state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  // Fetch FSM outputs and FIFO controls.
  always_comb begin
    spi_start  = 1'b0;
    fifo_push  = 1'b0;
    fifo_pop   = 1'b0;
    fifo_flush = ~enable;
    if (state == ST_REQ_HI || state == ST_REQ_LO) begin
      spi_start = 1'b1;
    end
    if (state == ST_PUSH && !discard) begin
      fifo_push = 1'b1;
    end
    if (enable && lr_event && !fifo_empty) begin
      fifo_pop = 1'b1;
    end
  end

  // Word-clock synchronizer plus edge history for lrclk, ready and enable.
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      lr_meta  <= 1'b0;
      lr_sync  <= 1'b0;
      lr_prev  <= 1'b0;
      rdy_prev <= 1'b0;
      en_prev  <= 1'b0;
    end else begin
      lr_meta  <= lrclk;
      lr_sync  <= lr_meta;
      lr_prev  <= lr_sync;
      rdy_prev <= spi_data_ready;
      en_prev  <= enable;
    end
  end

  // Remember an enable drop anywhere inside a transaction.
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      abort <= 1'b0;
    end else if (state == ST_IDLE) begin
      abort <= 1'b0;
    end else if (!enable) begin
      abort <= 1'b1;
    end
  end

  // Capture returned bytes on the accepted ready edge.
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      hi_bits <= '0;
      lo_byte <= '0;
    end else if (rdy_rise) begin
      if (state == ST_WAIT_HI) begin
        hi_bits <= spi_data[2:0];
      end
      if (state == ST_WAIT_LO) begin
        lo_byte <= spi_data;
      end
    end
  end

  // Sample pointer: reload on enable rising, advance after each kept sample.
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      cur_addr <= '0;
    end else if (en_rise) begin
      cur_addr <= start_addr;
    end else if (fifo_push) begin
      cur_addr <= next_addr;
    end
  end

  // Request address, held from the REQ cycle through its WAIT state.
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      spi_addr <= '0;
    end else if (state == ST_IDLE && state_nxt == ST_REQ_HI) begin
      spi_addr <= en_rise ? start_addr : cur_addr;
    end else if (state == ST_WAIT_HI && state_nxt == ST_REQ_LO) begin
      spi_addr <= spi_addr + ADDR_W'(1);
    end
  end

  // Presented sample: cleared while disabled, updated on each pop.
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      sample_data <= '0;
    end else if (!enable) begin
      sample_data <= '0;
    end else if (fifo_pop) begin
      sample_data <= fifo_rd_data;
    end
  end

  // Sticky underflow: set when a word-clock edge finds nothing to send.
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      underflow <= 1'b0;
    end else if (en_rise) begin
      underflow <= 1'b0;
    end else if (enable && lr_event && fifo_empty) begin
      underflow <= 1'b1;
    end
  end

  sample_fifo u_sample_fifo (
    .clk_in    (clk_in),
    .reset_n   (reset_n),
    .flush     (fifo_flush),
    .push      (fifo_push),
    .push_data (pack_sample(hi_bits, lo_byte)),
    .pop       (fifo_pop),
    .pop_data  (fifo_rd_data),
    .level     (fifo_level)
  );

endmodule
